// File: rtl/ex_result_sink.sv
// ALU result sink: classifies accepted results, resolves branch outcome,
// and queues them for memory/writeback with saturating event counters.
module ex_result_sink #(
    parameter int WORD  = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD-1:0]          in_result,
    input  logic                     in_zero,
    input  logic [10:0]              in_opcode,
    input  logic [4:0]               in_rd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD-1:0]          out_result,
    output logic [4:0]               out_rd,
    output logic [2:0]               out_class,
    output logic                     out_mem_write,
    output logic                     out_taken,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         cnt_r,
    output logic [CNT_W-1:0]         cnt_mem,
    output logic [CNT_W-1:0]         cnt_br_taken,
    output logic [CNT_W-1:0]         cnt_illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [WORD-1:0] result;
        logic [4:0]      rd;
        logic [2:0]      cls;
        logic            mw;
        logic            tk;
    } entry_t;

    entry_t            r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic [CNT_W-1:0]  r_cnt_r;
    logic [CNT_W-1:0]  r_cnt_mem;
    logic [CNT_W-1:0]  r_cnt_br;
    logic [CNT_W-1:0]  r_cnt_ill;

    logic [2:0]        w_class;
    logic              w_mw;
    logic              w_tk;
    logic              w_legal;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    entry_t            w_entry;
    entry_t            w_head;

    // Opcode decode; zero flag only matters for CBZ
    always_comb begin
        w_class = 3'b000;
        w_mw    = 1'b0;
        w_tk    = 1'b0;
        casez (in_opcode)
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: w_class = 3'b001;
            11'b11111000010: w_class = 3'b010;
            11'b11111000000: begin
                w_class = 3'b010;
                w_mw    = 1'b1;
            end
            11'b10110100???: begin
                w_class = 3'b100;
                w_tk    = in_zero;
            end
            11'b000101?????: begin
                w_class = 3'b100;
                w_tk    = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_legal   = |w_class;
    assign in_ready  = ~reset & (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign w_accept  = in_valid & in_ready;
    assign w_push    = w_accept & w_legal;
    assign w_pop     = out_valid & out_ready;

    assign w_entry = '{
        result: in_result,
        rd:     in_rd,
        cls:    w_class,
        mw:     w_mw,
        tk:     w_tk
    };

    assign w_head        = r_mem[r_rptr];
    assign out_result    = w_head.result;
    assign out_rd        = w_head.rd;
    assign out_class     = w_head.cls;
    assign out_mem_write = w_head.mw;
    assign out_taken     = w_head.tk;
    assign count         = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt_r   <= '0;
            r_cnt_mem <= '0;
            r_cnt_br  <= '0;
            r_cnt_ill <= '0;
        end else if (w_accept) begin
            if (w_class[0] && r_cnt_r != '1) begin
                r_cnt_r <= r_cnt_r + 1'b1;
            end
            if (w_class[1] && r_cnt_mem != '1) begin
                r_cnt_mem <= r_cnt_mem + 1'b1;
            end
            if (w_class[2] && w_tk && r_cnt_br != '1) begin
                r_cnt_br <= r_cnt_br + 1'b1;
            end
            if (!w_legal && r_cnt_ill != '1) begin
                r_cnt_ill <= r_cnt_ill + 1'b1;
            end
        end
    end

    assign cnt_r        = r_cnt_r;
    assign cnt_mem      = r_cnt_mem;
    assign cnt_br_taken = r_cnt_br;
    assign cnt_illegal  = r_cnt_ill;

endmodule
